// File: rtl/bc_pkg.sv
// Shared encodings for the Basic Computer datapath: bus sources and ALU ops.
// Latency: n/a (constants and pure helpers only).
// Backpressure: n/a.
package bc_pkg;

   // Common-bus source selects
   localparam logic [2:0] SEL_EXT = 3'd0;
   localparam logic [2:0] SEL_AR  = 3'd1;
   localparam logic [2:0] SEL_PC  = 3'd2;
   localparam logic [2:0] SEL_DR  = 3'd3;
   localparam logic [2:0] SEL_AC  = 3'd4;
   localparam logic [2:0] SEL_IR  = 3'd5;
   localparam logic [2:0] SEL_TR  = 3'd6;
   localparam logic [2:0] SEL_MEM = 3'd7;

   // ALU operations (AC source when LD_AC)
   localparam logic [2:0] OP_AND      = 3'd0;
   localparam logic [2:0] OP_ADD      = 3'd1;
   localparam logic [2:0] OP_PASS_DR  = 3'd2;
   localparam logic [2:0] OP_CMA      = 3'd3;
   localparam logic [2:0] OP_CIR      = 3'd4;
   localparam logic [2:0] OP_CIL      = 3'd5;
   localparam logic [2:0] OP_PASS_BUS = 3'd6;
   localparam logic [2:0] OP_HOLD     = 3'd7;

   // ALU result is one data word; the adder needs one extra bit for carry-out
   function automatic int alu_res_w(input int w);
      return w;
   endfunction

   function automatic int alu_sum_w(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/bc_reg_lic.sv
// Generic register with clear / load / increment, priority CLR > LD > INR > hold.
// Latency: 1 cycle (new value visible after the rising edge).
// Backpressure: none; controls are sampled every cycle.
module bc_reg_lic #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic         inr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Next value by priority; increment wraps naturally at all-ones
   always_comb begin
      q_d = q_q;
      if (clr_i)      q_d = '0;
      else if (ld_i)  q_d = d_i;
      else if (inr_i) q_d = q_q + W'(1);
   end

   // State register, cleared immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/bc_datapath_gen.sv
// Basic Computer datapath: common bus, registers, ALU with E flag, memory, sequence counter.
// Latency: register/E/SC/memory writes 1 cycle; BUS, flags and memory read combinational.
// Backpressure: none; the control unit drives every select/enable each cycle.
module bc_datapath_gen
   import bc_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int AWIDTH = 12,
   parameter int SC_W   = 4
) (
   input  logic                 clk,
   input  logic                 RST_N,
   input  logic [2:0]           BUS_SEL,
   input  logic [WIDTH-1:0]     EXT_IN,
   input  logic                 LD_AR, INR_AR, CLR_AR,
   input  logic                 LD_PC, INR_PC, CLR_PC,
   input  logic                 LD_DR, INR_DR, CLR_DR,
   input  logic                 LD_AC, INR_AC, CLR_AC,
   input  logic                 LD_TR, INR_TR, CLR_TR,
   input  logic                 LD_IR,
   input  logic [2:0]           ALU_OP,
   input  logic                 CLR_E,
   input  logic                 CME,
   input  logic                 WE_MEM,
   input  logic                 CLR_SC,
   output logic [WIDTH-1:0]     BUS,
   output logic [AWIDTH-1:0]    AR,
   output logic [AWIDTH-1:0]    PC,
   output logic [WIDTH-1:0]     AC,
   output logic [WIDTH-1:0]     IR,
   output logic                 E,
   output logic [2**SC_W-1:0]   T,
   output logic                 AC_ZERO,
   output logic                 AC_NEG,
   output logic                 DR_ZERO
);

   localparam int RES_W = alu_res_w(WIDTH);
   localparam int SUM_W = alu_sum_w(WIDTH);

   logic [AWIDTH-1:0] ar_q, pc_q;
   logic [WIDTH-1:0]  dr_q, ac_q, ir_q, tr_q;
   logic [SC_W-1:0]   sc_q;
   logic              e_q, e_d;
   logic [WIDTH-1:0]  bus;
   logic [WIDTH-1:0]  mem_rd;
   logic [RES_W-1:0]  alu_res;
   logic              alu_e;
   logic              alu_e_en;
   logic [SUM_W-1:0]  alu_sum;

   // Word-addressed memory; contents deliberately survive reset
   logic [WIDTH-1:0] mem_q [0:(2**AWIDTH)-1];

   assign mem_rd = mem_q[ar_q];

   // Common bus: 8:1 source mux, addresses zero-extended
   always_comb begin
      bus = '0;
      case (BUS_SEL)
         SEL_EXT: bus = EXT_IN;
         SEL_AR:  bus = WIDTH'(ar_q);
         SEL_PC:  bus = WIDTH'(pc_q);
         SEL_DR:  bus = dr_q;
         SEL_AC:  bus = ac_q;
         SEL_IR:  bus = ir_q;
         SEL_TR:  bus = tr_q;
         default: bus = mem_rd;
      endcase
   end

   // ALU: AC source and the carry value E would take for ADD/CIR/CIL
   always_comb begin
      alu_sum  = {1'b0, ac_q} + {1'b0, dr_q};
      alu_res  = ac_q;
      alu_e    = e_q;
      alu_e_en = 1'b0;
      case (ALU_OP)
         OP_AND:      alu_res = ac_q & dr_q;
         OP_ADD: begin
            alu_res  = alu_sum[WIDTH-1:0];
            alu_e    = alu_sum[WIDTH];
            alu_e_en = 1'b1;
         end
         OP_PASS_DR:  alu_res = dr_q;
         OP_CMA:      alu_res = ~ac_q;
         OP_CIR: begin
            alu_res  = {e_q, ac_q[WIDTH-1:1]};
            alu_e    = ac_q[0];
            alu_e_en = 1'b1;
         end
         OP_CIL: begin
            alu_res  = {ac_q[WIDTH-2:0], e_q};
            alu_e    = ac_q[WIDTH-1];
            alu_e_en = 1'b1;
         end
         OP_PASS_BUS: alu_res = bus;
         default:     alu_res = ac_q;
      endcase
   end

   // E next state: explicit clear/complement win over the ALU carry
   always_comb begin
      e_d = e_q;
      if (CLR_E)                  e_d = 1'b0;
      else if (CME)               e_d = ~e_q;
      else if (LD_AC && alu_e_en) e_d = alu_e;
   end

   // E flip-flop
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) e_q <= 1'b0;
      else        e_q <= e_d;
   end

   // Memory write uses the pre-edge AR, so LD_AR in the same cycle does not redirect it
   always_ff @(posedge clk) begin
      if (WE_MEM) mem_q[ar_q] <= bus;
   end

   bc_reg_lic #(.W(AWIDTH)) u_ar (.clk(clk), .rst_n(RST_N), .clr_i(CLR_AR), .ld_i(LD_AR),
      .inr_i(INR_AR), .d_i(bus[AWIDTH-1:0]), .q_o(ar_q));
   bc_reg_lic #(.W(AWIDTH)) u_pc (.clk(clk), .rst_n(RST_N), .clr_i(CLR_PC), .ld_i(LD_PC),
      .inr_i(INR_PC), .d_i(bus[AWIDTH-1:0]), .q_o(pc_q));
   bc_reg_lic #(.W(WIDTH))  u_dr (.clk(clk), .rst_n(RST_N), .clr_i(CLR_DR), .ld_i(LD_DR),
      .inr_i(INR_DR), .d_i(bus), .q_o(dr_q));
   bc_reg_lic #(.W(WIDTH))  u_ac (.clk(clk), .rst_n(RST_N), .clr_i(CLR_AC), .ld_i(LD_AC),
      .inr_i(INR_AC), .d_i(alu_res), .q_o(ac_q));
   bc_reg_lic #(.W(WIDTH))  u_ir (.clk(clk), .rst_n(RST_N), .clr_i(1'b0), .ld_i(LD_IR),
      .inr_i(1'b0), .d_i(bus), .q_o(ir_q));
   bc_reg_lic #(.W(WIDTH))  u_tr (.clk(clk), .rst_n(RST_N), .clr_i(CLR_TR), .ld_i(LD_TR),
      .inr_i(INR_TR), .d_i(bus), .q_o(tr_q));
   bc_reg_lic #(.W(SC_W))   u_sc (.clk(clk), .rst_n(RST_N), .clr_i(CLR_SC), .ld_i(1'b0),
      .inr_i(1'b1), .d_i('0), .q_o(sc_q));

   // Timing decode from registered SC so T never glitches mid-cycle
   always_comb begin
      T       = '0;
      T[sc_q] = 1'b1;
   end

   assign BUS     = bus;
   assign AR      = ar_q;
   assign PC      = pc_q;
   assign AC      = ac_q;
   assign IR      = ir_q;
   assign E       = e_q;
   assign AC_ZERO = (ac_q == '0);
   assign AC_NEG  = ac_q[WIDTH-1];
   assign DR_ZERO = (dr_q == '0);

endmodule

// File: tb/tb_bc_datapath_gen.sv
// Self-checking bench for bc_datapath_gen: directed scenarios plus randomized control
// against an integer-arithmetic reference model of the datapath rules.
module tb_bc_datapath_gen;

   logic        clk;
   logic        RST_N;
   logic [2:0]  BUS_SEL;
   logic [15:0] EXT_IN;
   logic        LD_AR, INR_AR, CLR_AR, LD_PC, INR_PC, CLR_PC, LD_DR, INR_DR, CLR_DR;
   logic        LD_AC, INR_AC, CLR_AC, LD_TR, INR_TR, CLR_TR, LD_IR;
   logic [2:0]  ALU_OP;
   logic        CLR_E, CME, WE_MEM, CLR_SC;
   logic [15:0] BUS;
   logic [11:0] AR, PC;
   logic [15:0] AC, IR;
   logic        E;
   logic [15:0] T;
   logic        AC_ZERO, AC_NEG, DR_ZERO;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (plain integers)
   int m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_sc, m_e;
   int mmem [4096];
   int saved_word;

   bc_datapath_gen #(.WIDTH(16), .AWIDTH(12), .SC_W(4)) dut (
      .clk(clk), .RST_N(RST_N), .BUS_SEL(BUS_SEL), .EXT_IN(EXT_IN),
      .LD_AR(LD_AR), .INR_AR(INR_AR), .CLR_AR(CLR_AR),
      .LD_PC(LD_PC), .INR_PC(INR_PC), .CLR_PC(CLR_PC),
      .LD_DR(LD_DR), .INR_DR(INR_DR), .CLR_DR(CLR_DR),
      .LD_AC(LD_AC), .INR_AC(INR_AC), .CLR_AC(CLR_AC),
      .LD_TR(LD_TR), .INR_TR(INR_TR), .CLR_TR(CLR_TR),
      .LD_IR(LD_IR), .ALU_OP(ALU_OP), .CLR_E(CLR_E), .CME(CME),
      .WE_MEM(WE_MEM), .CLR_SC(CLR_SC),
      .BUS(BUS), .AR(AR), .PC(PC), .AC(AC), .IR(IR), .E(E), .T(T),
      .AC_ZERO(AC_ZERO), .AC_NEG(AC_NEG), .DR_ZERO(DR_ZERO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_bus();
      case (BUS_SEL)
         3'd0: return int'(EXT_IN);
         3'd1: return m_ar;
         3'd2: return m_pc;
         3'd3: return m_dr;
         3'd4: return m_ac;
         3'd5: return m_ir;
         3'd6: return m_tr;
         default: return mmem[m_ar];
      endcase
   endfunction

   task automatic check_all();
      check_val("bus", 32'(BUS), 32'(m_bus()));
      check_val("ar", 32'(AR), 32'(m_ar));
      check_val("pc", 32'(PC), 32'(m_pc));
      check_val("ac", 32'(AC), 32'(m_ac));
      check_val("ir", 32'(IR), 32'(m_ir));
      check_val("e", 32'(E), 32'(m_e));
      check_val("t", 32'(T), 32'(1 << m_sc));
      check_val("ac_zero", 32'(AC_ZERO), 32'(m_ac == 0));
      check_val("ac_neg", 32'(AC_NEG), 32'(m_ac >= 32768));
      check_val("dr_zero", 32'(DR_ZERO), 32'(m_dr == 0));
   endtask

   function automatic int nxt(input int cur, input int ldv, input bit clr, input bit ld,
                              input bit inr, input int modulus);
      if (clr) return 0;
      if (ld)  return ldv % modulus;
      if (inr) return (cur + 1) % modulus;
      return cur;
   endfunction

   // One clock: predict from the datapath rules, then compare everything after the edge
   task automatic step();
      int b, res, ne, s;
      int n_ar, n_pc, n_dr, n_ac, n_ir, n_tr, n_e, n_sc;
      b   = m_bus();
      res = m_ac;
      ne  = m_e;
      case (ALU_OP)
         3'd0: res = m_ac & m_dr;
         3'd1: begin s = m_ac + m_dr; res = s % 65536; ne = s / 65536; end
         3'd2: res = m_dr;
         3'd3: res = 65535 - m_ac;
         3'd4: begin res = m_ac / 2 + m_e * 32768; ne = m_ac % 2; end
         3'd5: begin res = (m_ac * 2) % 65536 + m_e; ne = m_ac / 32768; end
         3'd6: res = b;
         default: res = m_ac;
      endcase
      n_ar = nxt(m_ar, b, CLR_AR, LD_AR, INR_AR, 4096);
      n_pc = nxt(m_pc, b, CLR_PC, LD_PC, INR_PC, 4096);
      n_dr = nxt(m_dr, b, CLR_DR, LD_DR, INR_DR, 65536);
      n_ac = nxt(m_ac, res, CLR_AC, LD_AC, INR_AC, 65536);
      n_ir = nxt(m_ir, b, 1'b0, LD_IR, 1'b0, 65536);
      n_tr = nxt(m_tr, b, CLR_TR, LD_TR, INR_TR, 65536);
      if (CLR_E) n_e = 0;
      else if (CME) n_e = 1 - m_e;
      else if (LD_AC && (ALU_OP == 3'd1 || ALU_OP == 3'd4 || ALU_OP == 3'd5)) n_e = ne;
      else n_e = m_e;
      n_sc = CLR_SC ? 0 : (m_sc + 1) % 16;
      if (WE_MEM) mmem[m_ar] = b;
      @(posedge clk);
      #1;
      m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac;
      m_ir = n_ir; m_tr = n_tr; m_e = n_e; m_sc = n_sc;
      check_all();
   endtask

   task automatic idle();
      BUS_SEL = 3'd0; EXT_IN = 16'h0; ALU_OP = 3'd7;
      {LD_AR, INR_AR, CLR_AR, LD_PC, INR_PC, CLR_PC, LD_DR, INR_DR, CLR_DR} = '0;
      {LD_AC, INR_AC, CLR_AC, LD_TR, INR_TR, CLR_TR, LD_IR} = '0;
      {CLR_E, CME, WE_MEM, CLR_SC} = '0;
   endtask

   task automatic model_reset();
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_sc = 0; m_e = 0;
   endtask

   initial begin
      idle();
      model_reset();
      RST_N = 1'b0;
      #2;
      check_all();
      #10 RST_N = 1'b1;              // released at t=12, between edges
      @(posedge clk); #1;
      m_sc = 1;                       // first edge after release counts SC up
      check_all();

      // Fill memory: write at old AR while AR increments, covering every word once
      for (int a = 0; a < 4096; a++) begin
         idle();
         EXT_IN = 16'($urandom);
         WE_MEM = 1'b1; INR_AR = 1'b1;
         step();
      end
      check_val("ar_wrap_after_fill", 32'(AR), 32'h0);

      // Host write then memory-to-DR transfer
      idle(); EXT_IN = 16'h0010; LD_AR = 1'b1; step();
      idle(); EXT_IN = 16'hBEEF; WE_MEM = 1'b1; step();
      idle(); BUS_SEL = 3'd7; LD_DR = 1'b1; step();
      idle(); BUS_SEL = 3'd3; #1;
      check_val("dr_beef", 32'(BUS), 32'h0000BEEF);
      check_val("dr_zero_clear", 32'(DR_ZERO), 32'h0);

      // ADD carry-out into E, then CLR_E overriding the carry in the same cycle
      idle(); EXT_IN = 16'hFFFF; ALU_OP = 3'd6; LD_AC = 1'b1; step();
      idle(); EXT_IN = 16'h0001; LD_DR = 1'b1; step();
      idle(); ALU_OP = 3'd1; LD_AC = 1'b1; step();
      check_val("add_ac", 32'(AC), 32'h0);
      check_val("add_e", 32'(E), 32'h1);
      check_val("add_ac_zero", 32'(AC_ZERO), 32'h1);
      idle(); EXT_IN = 16'hFFFF; ALU_OP = 3'd6; LD_AC = 1'b1; step();
      idle(); ALU_OP = 3'd1; LD_AC = 1'b1; CLR_E = 1'b1; step();
      check_val("add_clr_e", 32'(E), 32'h0);

      // Circulate left then right through E
      idle(); EXT_IN = 16'h8001; ALU_OP = 3'd6; LD_AC = 1'b1; CLR_E = 1'b1; step();
      idle(); ALU_OP = 3'd5; LD_AC = 1'b1; step();
      check_val("cil_ac", 32'(AC), 32'h0002);
      check_val("cil_e", 32'(E), 32'h1);
      idle(); ALU_OP = 3'd4; LD_AC = 1'b1; step();
      check_val("cir_ac", 32'(AC), 32'h8001);
      check_val("cir_e", 32'(E), 32'h0);
      check_val("cir_neg", 32'(AC_NEG), 32'h1);

      // PC wrap, CLR beating LD, and same-edge LD_AR + WE_MEM writing at the old AR
      idle(); EXT_IN = 16'h0FFF; LD_PC = 1'b1; step();
      idle(); INR_PC = 1'b1; step();
      check_val("pc_wrap", 32'(PC), 32'h0);
      idle(); EXT_IN = 16'h0ABC; LD_PC = 1'b1; step();
      idle(); EXT_IN = 16'h0ABC; LD_PC = 1'b1; CLR_PC = 1'b1; INR_PC = 1'b1; step();
      check_val("pc_clr_over_ld", 32'(PC), 32'h0);
      idle(); EXT_IN = 16'h0020; LD_AR = 1'b1; step();
      idle(); EXT_IN = 16'h0055; LD_AR = 1'b1; WE_MEM = 1'b1; step();
      check_val("ar_after_ld", 32'(AR), 32'h055);
      idle(); EXT_IN = 16'h0020; LD_AR = 1'b1; step();
      idle(); BUS_SEL = 3'd7; #1;
      check_val("write_at_old_ar", 32'(BUS), 32'h0055);

      // Sequence counter walk and wrap, then CLR_SC at T3
      idle(); CLR_SC = 1'b1; step();
      check_val("t0_after_clr", 32'(T), 32'h0001);
      idle();
      for (int i = 1; i <= 16; i++) begin
         step();
         check_val("t_walk", 32'(T), 32'(1 << (i % 16)));
      end
      step(); step(); step();
      check_val("t3", 32'(T), 32'h0008);
      CLR_SC = 1'b1; step();
      check_val("t_clr_at_t3", 32'(T), 32'h0001);

      // Randomized control traffic
      for (int n = 0; n < 3000; n++) begin
         BUS_SEL = 3'($urandom);
         EXT_IN  = 16'($urandom);
         ALU_OP  = 3'($urandom);
         LD_AR = ($urandom_range(0, 3) == 0); INR_AR = ($urandom_range(0, 3) == 0);
         CLR_AR = ($urandom_range(0, 15) == 0);
         LD_PC = ($urandom_range(0, 3) == 0); INR_PC = ($urandom_range(0, 3) == 0);
         CLR_PC = ($urandom_range(0, 15) == 0);
         LD_DR = ($urandom_range(0, 3) == 0); INR_DR = ($urandom_range(0, 3) == 0);
         CLR_DR = ($urandom_range(0, 15) == 0);
         LD_AC = ($urandom_range(0, 1) == 0); INR_AC = ($urandom_range(0, 3) == 0);
         CLR_AC = ($urandom_range(0, 15) == 0);
         LD_TR = ($urandom_range(0, 3) == 0); INR_TR = ($urandom_range(0, 3) == 0);
         CLR_TR = ($urandom_range(0, 15) == 0);
         LD_IR = ($urandom_range(0, 3) == 0);
         CLR_E = ($urandom_range(0, 7) == 0); CME = ($urandom_range(0, 7) == 0);
         WE_MEM = ($urandom_range(0, 3) == 0); CLR_SC = ($urandom_range(0, 15) == 0);
         step();
      end

      // Mid-cycle asynchronous reset with AC loaded; memory must survive
      idle(); EXT_IN = 16'h1234; ALU_OP = 3'd6; LD_AC = 1'b1; step();
      check_val("ac_preload", 32'(AC), 32'h1234);
      idle();
      saved_word = mmem[16];
      #3 RST_N = 1'b0;
      #1;
      model_reset();
      check_val("rst_ac", 32'(AC), 32'h0);
      check_val("rst_pc", 32'(PC), 32'h0);
      check_val("rst_ar", 32'(AR), 32'h0);
      check_val("rst_e", 32'(E), 32'h0);
      check_val("rst_t", 32'(T), 32'h0001);
      check_all();
      #2 RST_N = 1'b1;
      step();
      EXT_IN = 16'h0010; LD_AR = 1'b1; step();
      idle(); BUS_SEL = 3'd7; #1;
      check_val("mem_retained", 32'(BUS), 32'(saved_word));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bc_datapath_gen.md
# bc_datapath_gen

Parametrised successor to the Basic Computer datapath: one common bus joining AR, PC, DR, AC, IR, TR and a word-addressed memory, plus a functional ALU with op select, an E (carry) flip-flop, a sequence counter with a decoded timing output, and status flags. Sits between the control unit (drives all select and enable inputs) and the host/testbench (preloads memory through the external bus channel). Data width and address width are generics; memory depth follows from address width.

## Interface
- WIDTH, 16, data word width (bus, DR, AC, IR, TR, memory words)
- AWIDTH, 12, address width (AR, PC); must be ≤ WIDTH; memory depth = 2^AWIDTH
- SC_W, 4, sequence-counter width; T output is 2^SC_W one-hot
- clk  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- BUS_SEL  in  3  bus source: 0 EXT_IN, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
- EXT_IN  in  WIDTH  host/input data onto bus
- LD_x, INR_x, CLR_x  in  1 each  for x ∈ {AR, PC, DR, AC, TR}; IR has LD_IR only
- ALU_OP  in  3  AC source when LD_AC: 0 AND, 1 ADD, 2 PASS_DR, 3 CMA, 4 CIR, 5 CIL, 6 PASS_BUS, 7 HOLD
- CLR_E, CME  in  1  clear / complement E
- WE_MEM  in  1  memory write enable
- CLR_SC  in  1  clear sequence counter
- BUS  out  WIDTH  current bus value
- AR, PC  out  AWIDTH  register values
- AC, IR  out  WIDTH  register values
- E  out  1  carry flip-flop
- T  out  2^SC_W  one-hot decode of SC
- AC_ZERO, AC_NEG, DR_ZERO  out  1  AC==0, AC[WIDTH-1], DR==0

## Operation
- Bus is a combinational 8:1 mux; AR/PC zero-extended to WIDTH; AR/PC load BUS[AWIDTH-1:0].
- Per register priority: CLR > LD > INR > hold. INR wraps all-ones → 0.
- DR, IR, TR load from BUS; AC loads ALU result.
- ALU (combinational): AND = AC&DR; ADD = AC+DR, carry-out = bit WIDTH of sum; CMA = ~AC; CIR = {E, AC[WIDTH-1:1]}, new E = AC[0]; CIL = {AC[WIDTH-2:0], E}, new E = AC[WIDTH-1]; PASS_DR, PASS_BUS; HOLD leaves AC unchanged even if LD_AC.
- E priority: CLR_E > CME > ALU update (only when LD_AC and ALU_OP ∈ {ADD, CIR, CIL}) > hold.
- INR_AC/CLR_AC override per register priority (CLR_AC beats LD_AC).
- Memory: asynchronous read of mem[AR] onto bus channel 7; synchronous write of BUS to mem[AR] when WE_MEM. Write uses pre-edge AR even if LD_AR same cycle. WE_MEM with BUS_SEL=MEM rewrites same value.
- SC increments every cycle, wraps 2^SC_W-1 → 0; CLR_SC forces 0 next edge.
- Reset: AR, PC, DR, AC, IR, TR, SC, E all 0; T = 1 (T0); flags AC_ZERO=1, DR_ZERO=1, AC_NEG=0. Memory contents not reset and retained across mid-operation reset.

## Timing
- Register, E, SC and memory updates: 1-cycle latency (visible after rising edge).
- BUS, flags, memory read: combinational from current state/inputs, same cycle.
- T decoded from registered SC (glitch-free relative to clk).
- Reset asserts immediately (no clock), releases synchronously-safe: first update on first rising edge after RST_N high.
- Read-after-write: write at edge n visible on BUS (SEL=MEM) in cycle n+1.

## Structure
- Package bc_pkg: BUS_SEL encodings (SEL_EXT…SEL_MEM), ALU_OP encodings (OP_AND…OP_HOLD), ALU result/carry width helpers.
- Sub-module bc_reg_lic #(W): async active-low reset register with CLR/LD/INR priority; instantiated for AR, PC, DR, AC, IR (INR/CLR tied 0), TR, SC (LD tied 0).
- Memory and ALU inline or as local always blocks; no further sub-modules required.

## Test plan (WIDTH=16, AWIDTH=12, SC_W=4)
- Pulse RST_N low mid-cycle after loading AC=0x1234 → AC, PC, AR, E, SC = 0, T=0x0001 immediately; memory word at 0x010 unchanged.
- EXT_IN=0x0010, SEL_EXT, LD_AR; then EXT_IN=0xBEEF, WE_MEM; then SEL_MEM, LD_DR → DR=0xBEEF, DR_ZERO=0.
- AC=0xFFFF, DR=0x0001, OP_ADD, LD_AC → AC=0x0000, E=1, AC_ZERO=1; same cycle with CLR_E → E=0.
- AC=0x8001, E=0, OP_CIL → AC=0x0002, E=1; then OP_CIR → AC=0x8001, E=0, AC_NEG=1.
- PC=0xFFF, INR_PC → PC=0x000; CLR_PC+LD_PC (BUS=0x0ABC) → PC=0x000; LD_AR+WE_MEM same edge writes at old AR.
- 16 free-running cycles → T walks 0x0001…0x8000 → 0x0001; CLR_SC at T3 → T=0x0001 next cycle.
